frame_scheduler: RTL and testbench

//  Per-frame sequencer for the game datapath. Consumes the frame tick (enable_frame) from the frame delay counter.

---
 rtl/bs_frame_pkg.sv | 40 ++++
 rtl/frame_scheduler_speed_level_ctrl.sv | 45 ++++
 rtl/frame_scheduler.sv | 156 +++++++++++++++
 tb/tb_frame_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_frame_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding, default
// speed parameters and the fps_count reload function.
package bs_frame_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        ERASE     = 3'd2,
        UPDATE    = 3'd3,
        DRAW      = 3'd4
    } frame_state_t;

    localparam logic [31:0] FPS_BASE_DEFAULT   = 32'd833332;
    localparam logic [31:0] FPS_STEP_DEFAULT   = 32'd83333;
    localparam logic [31:0] FPS_MIN_DEFAULT    = 32'd166666;
    localparam int          NUM_LEVELS_DEFAULT = 8;
    localparam int          LEVEL_OUT_W        = 3;

    // Reload value for a speed level: base minus level*step, floored at the
    // minimum. An underflowing subtraction also lands on the floor.
    function automatic logic [31:0] fps_reload(
        input logic [31:0] lvl,
        input logic [31:0] base,
        input logic [31:0] step,
        input logic [31:0] floor_val
    );
        logic [31:0] prod;
        logic [31:0] diff;
        prod = lvl * step;
        diff = base - prod;
        if (prod > base) begin
            return floor_val;
        end else if (diff < floor_val) begin
            return floor_val;
        end else begin
            return diff;
        end
    endfunction

endpackage

// File: rtl/frame_scheduler_speed_level_ctrl.sv
// Speed level register and the registered reload value derived from it.
// fps_count follows level with one cycle of latency.
module speed_level_ctrl
    import bs_frame_pkg::*;
#(
    parameter logic [31:0] FPS_BASE   = FPS_BASE_DEFAULT,
    parameter logic [31:0] FPS_STEP   = FPS_STEP_DEFAULT,
    parameter logic [31:0] FPS_MIN    = FPS_MIN_DEFAULT,
    parameter int          NUM_LEVELS = NUM_LEVELS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   level_up,
    input  logic                   level_rst,
    output logic [LEVEL_OUT_W-1:0] level,
    output logic [31:0]            fps_count
);

    localparam int LEVEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);

    logic [LEVEL_W-1:0] level_q;

    // Level steps up to its ceiling on level_up; level_rst wins and returns to 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            level_q   <= '0;
            fps_count <= FPS_BASE;
        end else begin
            if (level_rst) begin
                level_q <= '0;
            end else if (level_up && (level_q != LEVEL_MAX)) begin
                level_q <= level_q + LEVEL_W'(1);
            end
            fps_count <= fps_reload(32'(level_q), FPS_BASE, FPS_STEP, FPS_MIN);
        end
    end

    // Zero-extend the internal level to the fixed-width output.
    always_comb begin
        level                = '0;
        level[LEVEL_W-1:0]   = level_q;
    end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: one erase -> update -> draw pass per frame tick,
// with one tick of buffering (pending) and overrun detection.
// Optional feature macro: FRAME_OVERRUN_CNT_EN builds the 8-bit saturating
// dropped-tick counter; without it overrun_cnt is tied to 0.
module frame_scheduler
    import bs_frame_pkg::*;
#(
    parameter logic [31:0] FPS_BASE   = FPS_BASE_DEFAULT,
    parameter logic [31:0] FPS_STEP   = FPS_STEP_DEFAULT,
    parameter logic [31:0] FPS_MIN    = FPS_MIN_DEFAULT,
    parameter int          NUM_LEVELS = NUM_LEVELS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   run,
    input  logic                   enable_frame,
    input  logic                   erase_done,
    input  logic                   draw_done,
    input  logic                   level_up,
    input  logic                   level_rst,
    output logic                   delay_en,
    output logic [31:0]            fps_count,
    output logic                   erase_req,
    output logic                   update_en,
    output logic                   draw_req,
    output logic [LEVEL_OUT_W-1:0] level,
    output logic                   frame_overrun,
    output logic [7:0]             overrun_cnt
);

    frame_state_t state;
    logic         pending;
    logic         busy;
    logic         consume;
    logic         tick_dropped;

    speed_level_ctrl #(
        .FPS_BASE   (FPS_BASE),
        .FPS_STEP   (FPS_STEP),
        .FPS_MIN    (FPS_MIN),
        .NUM_LEVELS (NUM_LEVELS)
    ) u_speed (
        .clk       (clk),
        .resetn    (resetn),
        .level_up  (level_up),
        .level_rst (level_rst),
        .level     (level),
        .fps_count (fps_count)
    );

    // A tick is lost when one is already buffered and not being consumed now.
    always_comb begin
        busy         = (state == ERASE) || (state == UPDATE) || (state == DRAW);
        consume      = (state == DRAW) && draw_done && pending;
        tick_dropped = busy && enable_frame && pending && !consume;
    end

    // Frame sequencer with registered request/pulse outputs and the pending tick.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            erase_req <= 1'b0;
            update_en <= 1'b0;
            draw_req  <= 1'b0;
            delay_en  <= 1'b0;
            pending   <= 1'b0;
        end else begin
            delay_en  <= run;
            update_en <= 1'b0;
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    if (run) begin
                        state <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (!run) begin
                        state   <= IDLE;
                        pending <= 1'b0;
                    end else if (enable_frame || pending) begin
                        state     <= ERASE;
                        erase_req <= 1'b1;
                        pending   <= pending && enable_frame;
                    end
                end
                ERASE: begin
                    if (enable_frame) begin
                        pending <= 1'b1;
                    end
                    if (erase_done) begin
                        state     <= UPDATE;
                        erase_req <= 1'b0;
                        update_en <= 1'b1;
                    end
                end
                UPDATE: begin
                    if (enable_frame) begin
                        pending <= 1'b1;
                    end
                    state    <= DRAW;
                    draw_req <= 1'b1;
                end
                DRAW: begin
                    if (draw_done) begin
                        draw_req <= 1'b0;
                        pending  <= enable_frame;
                        if (pending) begin
                            state     <= ERASE;
                            erase_req <= 1'b1;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end else if (enable_frame) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    erase_req <= 1'b0;
                    draw_req  <= 1'b0;
                    pending   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag; a drop in the same cycle as level_rst still registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= tick_dropped || (frame_overrun && !level_rst);
        end
    end

`ifdef FRAME_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    // Saturating count of dropped ticks, cleared together with the level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun_q <= 8'd0;
        end else if (level_rst) begin
            overrun_q <= tick_dropped ? 8'd1 : 8'd0;
        end else if (tick_dropped && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign overrun_cnt = overrun_q;
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: frame handshakes, pending/overrun,
// run drop mid-frame, reset mid-frame and a table of speed-level vectors.
module tb_frame_scheduler;

    logic        clk;
    logic        resetn;
    logic        run;
    logic        enable_frame;
    logic        erase_done;
    logic        draw_done;
    logic        level_up;
    logic        level_rst;
    logic        delay_en;
    logic [31:0] fps_count;
    logic        erase_req;
    logic        update_en;
    logic        draw_req;
    logic [2:0]  level;
    logic        frame_overrun;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    typedef struct {
        logic        up;
        logic        rst;
        logic [2:0]  exp_level;
        logic [31:0] exp_fps;
    } level_vec_t;

    level_vec_t vecs[$];

`ifdef FRAME_OVERRUN_CNT_EN
    localparam logic [31:0] EXP_CNT_AFTER_DROP = 32'd1;
`else
    localparam logic [31:0] EXP_CNT_AFTER_DROP = 32'd0;
`endif

    frame_scheduler dut (
        .clk           (clk),
        .resetn        (resetn),
        .run           (run),
        .enable_frame  (enable_frame),
        .erase_done    (erase_done),
        .draw_done     (draw_done),
        .level_up      (level_up),
        .level_rst     (level_rst),
        .delay_en      (delay_en),
        .fps_count     (fps_count),
        .erase_req     (erase_req),
        .update_en     (update_en),
        .draw_req      (draw_req),
        .level         (level),
        .frame_overrun (frame_overrun),
        .overrun_cnt   (overrun_cnt)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference reload value, written as signed arithmetic with a floor.
    function automatic logic [31:0] ref_fps(input int lvl);
        int v;
        v = 833332 - lvl * 83333;
        if (v < 166666) v = 166666;
        return 32'(v);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_entry_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] actual);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got %0d expected an entry", actual);
        end else begin
            e = sb_q.pop_front();
            check_output(e.name, actual, e.exp);
        end
    endtask

    // Advance one clock; inputs and samples both land 1 ns after the edge.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    // Runs a frame whose erase_req is already high at the current sample.
    task automatic run_frame(input int e_len, input int d_len, input int draw_ticks, input bit drop_run);
        int ce;
        int cd;
        int cu;
        int g;
        ce = 0;
        cd = 0;
        cu = 0;
        sb_push("erase_req_cycles", 32'(e_len));
        sb_push("update_en_pulses", 32'd1);
        sb_push("draw_req_cycles", 32'(d_len));
        g = 0;
        while (erase_req && g < 200) begin
            ce++;
            if (drop_run && ce == 2) run = 1'b0;
            cu += int'(update_en);
            erase_done = (ce == e_len);
            apply_stimulus();
            g++;
        end
        erase_done = 1'b0;
        cu += int'(update_en);
        apply_stimulus();
        g = 0;
        while (draw_req && g < 200) begin
            cd++;
            cu += int'(update_en);
            enable_frame = (draw_ticks >= 1 && cd == 2) || (draw_ticks >= 2 && cd == 4);
            draw_done = (cd == d_len);
            apply_stimulus();
            g++;
        end
        enable_frame = 1'b0;
        draw_done    = 1'b0;
        sb_check(32'(ce));
        sb_check(32'(cu));
        sb_check(32'(cd));
    endtask

    // Pulse the frame tick and expect erase_req one edge later.
    task automatic tick_and_expect_erase(input string name);
        enable_frame = 1'b1;
        apply_stimulus();
        enable_frame = 1'b0;
        check_output(name, 32'(erase_req), 32'd1);
    endtask

    task automatic add_vec(input logic up, input logic rst, input int lvl);
        level_vec_t v;
        v.up        = up;
        v.rst       = rst;
        v.exp_level = 3'(lvl);
        v.exp_fps   = ref_fps(lvl);
        vecs.push_back(v);
    endtask

    // Main test sequence.
    initial begin
        int seen;
        resetn       = 1'b0;
        run          = 1'b0;
        enable_frame = 1'b0;
        erase_done   = 1'b0;
        draw_done    = 1'b0;
        level_up     = 1'b0;
        level_rst    = 1'b0;
        apply_stimulus();
        apply_stimulus();

        check_output("rst_erase_req", 32'(erase_req), 32'd0);
        check_output("rst_draw_req", 32'(draw_req), 32'd0);
        check_output("rst_update_en", 32'(update_en), 32'd0);
        check_output("rst_delay_en", 32'(delay_en), 32'd0);
        check_output("rst_level", 32'(level), 32'd0);
        check_output("rst_fps_count", fps_count, 32'd833332);
        check_output("rst_frame_overrun", 32'(frame_overrun), 32'd0);
        check_output("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);

        // Basic frame: 6 erase cycles, one update pulse, 8 draw cycles.
        resetn = 1'b1;
        run    = 1'b1;
        apply_stimulus();
        apply_stimulus();
        check_output("run_delay_en", 32'(delay_en), 32'd1);
        check_output("wait_no_erase", 32'(erase_req), 32'd0);
        tick_and_expect_erase("tick_latency_erase_req");
        run_frame(6, 8, 0, 1'b0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            seen += int'(erase_req) + int'(draw_req);
            apply_stimulus();
        end
        check_output("back_to_wait_idle_reqs", 32'(seen), 32'd0);

        // Pending tick during draw chains straight into erase; third tick drops.
        tick_and_expect_erase("tick2_erase_req");
        run_frame(3, 8, 2, 1'b0);
        check_output("pending_direct_erase", 32'(erase_req), 32'd1);
        check_output("overrun_flag", 32'(frame_overrun), 32'd1);
        check_output("overrun_cnt", 32'(overrun_cnt), EXP_CNT_AFTER_DROP);
        run_frame(2, 2, 0, 1'b0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            seen += int'(erase_req);
            apply_stimulus();
        end
        check_output("pending_consumed", 32'(seen), 32'd0);
        check_output("overrun_sticky", 32'(frame_overrun), 32'd1);

        // Speed level vectors: step up, simultaneous up+rst, saturation, reset.
        add_vec(1'b1, 1'b0, 1);
        add_vec(1'b1, 1'b0, 2);
        add_vec(1'b1, 1'b0, 3);
        add_vec(1'b1, 1'b1, 0);
        for (int i = 1; i <= 9; i++) add_vec(1'b1, 1'b0, (i > 7) ? 7 : i);
        add_vec(1'b0, 1'b1, 0);
        foreach (vecs[i]) begin
            level_up  = vecs[i].up;
            level_rst = vecs[i].rst;
            sb_push($sformatf("vec%0d_level", i), 32'(vecs[i].exp_level));
            sb_push($sformatf("vec%0d_fps_count", i), vecs[i].exp_fps);
            apply_stimulus();
            level_up  = 1'b0;
            level_rst = 1'b0;
            apply_stimulus();
            sb_check(32'(level));
            sb_check(fps_count);
        end
        check_output("level_rst_clears_overrun", 32'(frame_overrun), 32'd0);
        check_output("level_rst_clears_cnt", 32'(overrun_cnt), 32'd0);

        // Dropping run mid-erase still finishes the frame, then parks in IDLE.
        tick_and_expect_erase("tick3_erase_req");
        run_frame(4, 4, 0, 1'b1);
        apply_stimulus();
        apply_stimulus();
        check_output("run_low_delay_en", 32'(delay_en), 32'd0);
        enable_frame = 1'b1;
        apply_stimulus();
        enable_frame = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            seen += int'(erase_req);
            apply_stimulus();
        end
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            seen += int'(erase_req);
            apply_stimulus();
        end
        check_output("idle_ignores_tick", 32'(seen), 32'd0);

        // Reset while draw_req is high, with a raised level and an overrun.
        level_up = 1'b1;
        apply_stimulus();
        apply_stimulus();
        level_up = 1'b0;
        apply_stimulus();
        check_output("pre_reset_fps", fps_count, ref_fps(2));
        tick_and_expect_erase("tick4_erase_req");
        erase_done = 1'b1;
        apply_stimulus();
        erase_done = 1'b0;
        apply_stimulus();
        check_output("pre_reset_draw_req", 32'(draw_req), 32'd1);
        enable_frame = 1'b1;
        apply_stimulus();
        apply_stimulus();
        enable_frame = 1'b0;
        check_output("pre_reset_overrun", 32'(frame_overrun), 32'd1);
        resetn = 1'b0;
        apply_stimulus();
        check_output("mid_rst_draw_req", 32'(draw_req), 32'd0);
        check_output("mid_rst_erase_req", 32'(erase_req), 32'd0);
        check_output("mid_rst_level", 32'(level), 32'd0);
        check_output("mid_rst_fps_count", fps_count, 32'd833332);
        check_output("mid_rst_overrun", 32'(frame_overrun), 32'd0);
        check_output("mid_rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
        check_output("mid_rst_delay_en", 32'(delay_en), 32'd0);
        resetn = 1'b1;
        apply_stimulus();

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
